pdm_decimator: RTL and testbench

Receive-side counterpart of the synth output path. It takes the 1-bit sigma-delta stream that `dac` emits at the modulator rate, passes it through a 3rd-order CIC decimator (R = 512), and recovers 16-bit unsigned PCM at the sample rate, 20.48 MHz / 512 = 40 kHz. It is used as the loopback checker behind `dac` and as the input front end for an external PDM source.

---
 rtl/pdm_decimator.sv | 119 +++++++++++
 tb/tb_pdm_decimator.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/pdm_decimator.sv
// pdm_decimator: 3rd-order CIC decimator turning a 1-bit PDM stream into unsigned PCM.
module pdm_decimator #(
    parameter int unsigned DEC_LOG2 = 9,
    parameter int unsigned OUT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    output logic [OUT_W-1:0] dout,
    output logic             dout_valid,
    output logic             sat
);

    localparam int unsigned W     = 3 * DEC_LOG2 + 1;
    localparam int unsigned SHIFT = 3 * DEC_LOG2 - OUT_W;
    localparam int unsigned WARM_W = 2;

    logic                s1_q, s1_d;
    logic                s2_q, s2_d;
    logic [W-1:0]        i1_q, i1_d;
    logic [W-1:0]        i2_q, i2_d;
    logic [W-1:0]        i3_q, i3_d;
    logic [W-1:0]        d1_q, d1_d;
    logic [W-1:0]        d2_q, d2_d;
    logic [W-1:0]        d3_q, d3_d;
    logic [DEC_LOG2-1:0] cnt_q, cnt_d;
    logic [WARM_W-1:0]   warm_q, warm_d;
    logic [OUT_W-1:0]    dout_q, dout_d;
    logic                dout_valid_q, dout_valid_d;
    logic                sat_q, sat_d;

    logic                tick_c;
    logic [W-1:0]        c1_c, c2_c, c3_c;
    logic [W-1:0]        q_c;
    logic                clip_c;

    // Comb section and output scaling; values are only committed on a tick.
    always_comb begin
        tick_c = &cnt_q;
        c1_c   = i3_q - d1_q;
        c2_c   = c1_c - d2_q;
        c3_c   = c2_c - d3_q;
        q_c    = c3_c >> SHIFT;
        clip_c = |q_c[W-1:OUT_W];
    end

    // Next-state: sync, integrators, decimation counter, comb delays, outputs.
    always_comb begin
        s1_d         = din;
        s2_d         = s1_q;
        i1_d         = i1_q + W'(s2_q);
        i2_d         = i2_q + i1_q;
        i3_d         = i3_q + i2_q;
        cnt_d        = cnt_q + DEC_LOG2'(1);
        d1_d         = d1_q;
        d2_d         = d2_q;
        d3_d         = d3_q;
        warm_d       = warm_q;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        sat_d        = sat_q;

        if (tick_c) begin
            d1_d = i3_q;
            d2_d = c1_c;
            d3_d = c2_c;
            if (clip_c) begin
                dout_d = '1;
                sat_d  = 1'b1;
            end else begin
                dout_d = q_c[OUT_W-1:0];
            end
            // Comb delays need three ticks to hold real history before outputs are trusted.
            if (warm_q == WARM_W'(3)) begin
                dout_valid_d = 1'b1;
            end else begin
                warm_d = warm_q + WARM_W'(1);
            end
        end
    end

    // State registers with synchronous active-low reset; reset overrides any tick.
    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_q         <= 1'b0;
            s2_q         <= 1'b0;
            i1_q         <= '0;
            i2_q         <= '0;
            i3_q         <= '0;
            d1_q         <= '0;
            d2_q         <= '0;
            d3_q         <= '0;
            cnt_q        <= '0;
            warm_q       <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            sat_q        <= 1'b0;
        end else begin
            s1_q         <= s1_d;
            s2_q         <= s2_d;
            i1_q         <= i1_d;
            i2_q         <= i2_d;
            i3_q         <= i3_d;
            d1_q         <= d1_d;
            d2_q         <= d2_d;
            d3_q         <= d3_d;
            cnt_q        <= cnt_d;
            warm_q       <= warm_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            sat_q        <= sat_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign sat        = sat_q;

endmodule

// File: tb/tb_pdm_decimator.sv
// Directed bench for pdm_decimator: constant, periodic, step, mid-stream reset and modulator loopback streams.
module tb_pdm_decimator;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        din = 1'b0;
    logic [15:0] dout;
    logic        dout_valid;
    logic        sat;

    int          errors = 0;
    int          checks = 0;
    int          cyc    = 0;
    logic [15:0] sd_acc = '0;
    logic        hold_pending = 1'b0;
    logic [15:0] held = '0;
    logic [15:0] prev = '0;
    int          nval = 0;

    pdm_decimator #(.DEC_LOG2(9), .OUT_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .dout       (dout),
        .dout_valid (dout_valid),
        .sat        (sat)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Stream patterns indexed by cycle since reset release.
    function automatic logic pat(input int mode, input int c);
        case (mode)
            0:       pat = 1'b0;
            1:       pat = 1'b1;
            2:       pat = (c % 2) == 0;
            3:       pat = (c % 2) == 1;
            4:       pat = (c % 4) == 0;
            5:       pat = (c % 4) != 3;
            default: pat = 1'b0;
        endcase
    endfunction

    // One-cycle reset; outputs must be cleared right after the reset edge.
    task automatic do_reset();
        rst = 1'b0;
        din = 1'b0;
        @(posedge clk);
        #1;
        check("rst_dout", 32'(dout), 32'h0);
        check("rst_valid", 32'(dout_valid), 32'h0);
        check("rst_sat", 32'(sat), 32'h0);
        rst          = 1'b1;
        cyc          = 0;
        sd_acc       = '0;
        hold_pending = 1'b0;
    endtask

    // Drive n cycles of a pattern (mode 6 = first-order modulator at 0x4000) and check every strobe.
    task automatic run(input int mode, input int n, input int exp_val, input int exp_sat,
                       input int tol, input bit mono);
        logic exp_v;
        for (int k = 0; k < n; k++) begin
            if (mode == 6) begin
                {din, sd_acc} = 17'(sd_acc) + 17'h4000;
            end else begin
                din = pat(mode, cyc);
            end
            @(posedge clk);
            #1;
            if (hold_pending) begin
                check("hold", 32'(dout), 32'(held));
                hold_pending = 1'b0;
            end
            exp_v = (cyc >= 2047) && ((cyc % 512) == 511);
            if (dout_valid || exp_v) begin
                check("strobe", 32'(dout_valid), 32'(exp_v));
            end
            if (dout_valid) begin
                hold_pending = 1'b1;
                held         = dout;
                check("sat", 32'(sat), 32'(exp_sat));
                if (mono) begin
                    check("mono", 32'(dout >= prev), 32'h1);
                    prev = dout;
                    nval++;
                    if (nval >= 4) check("settle", 32'(dout), 32'(exp_val));
                end else if (tol == 0) begin
                    check("dout", 32'(dout), 32'(exp_val));
                end else begin
                    check("dout_tol", 32'((int'(dout) >= exp_val - tol) && (int'(dout) <= exp_val + tol)), 32'h1);
                end
            end
            cyc++;
        end
    endtask

    initial begin
        do_reset();
        run(0, 4096, 16'h0000, 0, 0, 1'b0);

        do_reset();
        run(1, 4096, 16'hFFFF, 1, 0, 1'b0);

        do_reset();
        run(2, 4096, 16'h8000, 0, 0, 1'b0);

        do_reset();
        run(3, 4096, 16'h8000, 0, 0, 1'b0);

        // Step from density 1/4 to 3/4 right after a strobe, keeping pattern phase.
        do_reset();
        run(4, 3072, 16'h4000, 0, 0, 1'b0);
        prev = 16'h4000;
        nval = 0;
        run(5, 2560, 16'hC000, 0, 0, 1'b1);
        check("step_seen", 32'(nval), 32'd5);

        // Reset in the middle of an alternating stream.
        do_reset();
        run(2, 1300, 16'h8000, 0, 0, 1'b0);
        do_reset();
        run(2, 2560, 16'h8000, 0, 0, 1'b0);

        // Loopback from a first-order modulator at 0x4000.
        do_reset();
        run(6, 4096, 16'h4000, 0, 4, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
